// File: rtl/bnn_seq_pkg.sv
// Shared types and sizing helpers for the binary-neural-network layer sequencer.
package bnn_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECIDE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Accumulator must hold every value 0..n inclusive.
  function automatic int acc_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Counter/address width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bnn_layer_seq_xnor_popcnt.sv
// Combinational XNOR + popcount over one weight chunk.
module xnor_popcnt #(
  parameter  int CHUNK = 8,
  localparam int PW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [PW-1:0]    cnt
);

  // Count positions where activation and weight agree.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < CHUNK; i++) begin
      cnt = cnt + PW'(~(a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/bnn_layer_seq.sv
// Sequential binary neural-network layer: evaluates NNEURON neurons of an
// N-bit XNOR/popcount dot product, one CHUNK-bit weight chunk per accepted
// w_valid, using a single shared popcount unit.
// Optional build macro: BNN_THRESH_EN adds a per-run programmable threshold
// port (thr); without it the threshold is fixed at N (majority of bits).
//
// state  | meaning
// IDLE   | waiting for start; out_vec holds last run's results
// FETCH  | requesting weight chunk at w_addr, accumulating on w_valid
// DECIDE | compare 2*acc against threshold, emit neuron result
// DONE   | one-cycle end-of-run pulse
module bnn_layer_seq
  import bnn_seq_pkg::*;
#(
  parameter  int CHUNK   = 8,
  parameter  int NCHUNK  = 4,
  parameter  int NNEURON = 4,
  localparam int N       = CHUNK * NCHUNK,
  localparam int AW      = acc_width(N),
  localparam int TW      = AW + 1,
  localparam int ADRW    = clog2_min1(NNEURON * NCHUNK),
  localparam int NW      = clog2_min1(NNEURON),
  localparam int CKW     = clog2_min1(NCHUNK),
  localparam int PW      = $clog2(CHUNK + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N-1:0]       act_vec,
`ifdef BNN_THRESH_EN
  input  logic [TW-1:0]      thr,
`endif
  output logic               w_req,
  output logic [ADRW-1:0]    w_addr,
  input  logic               w_valid,
  input  logic [CHUNK-1:0]   w_data,
  output logic               o_valid,
  output logic [NW-1:0]      o_idx,
  output logic               o_bit,
  output logic [NNEURON-1:0] out_vec,
  output logic               busy,
  output logic               done
);

  state_t           state_q, state_d;
  logic [N-1:0]     act_q;
  logic [NW-1:0]    neuron_q;
  logic [CKW-1:0]   chunk_q;
  logic [AW-1:0]    acc_q;
  logic [CHUNK-1:0] act_chunk;
  logic [PW-1:0]    pc;
  logic [AW-1:0]    acc_sum;
  logic [TW-1:0]    thr_eff;
  logic             dec_bit;
  logic             last_chunk;
  logic             last_neuron;

`ifdef BNN_THRESH_EN
  logic [TW-1:0] thr_q;

  // Threshold is captured with the activation so it cannot change mid-run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thr_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      thr_q <= thr;
    end
  end

  assign thr_eff = thr_q;
`else
  assign thr_eff = TW'(N);
`endif

  assign act_chunk   = act_q[chunk_q*CHUNK +: CHUNK];
  assign last_chunk  = (chunk_q == CKW'(NCHUNK - 1));
  assign last_neuron = (neuron_q == NW'(NNEURON - 1));
  assign acc_sum     = acc_q + AW'(pc);
  // 2*acc is formed by a left shift into the extra bit, so it cannot overflow.
  assign dec_bit     = ({acc_q, 1'b0} >= thr_eff);

  assign w_addr = ADRW'(neuron_q) * ADRW'(NCHUNK) + ADRW'(chunk_q);
  assign w_req  = (state_q == S_FETCH);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

  xnor_popcnt #(.CHUNK(CHUNK)) u_pop (
    .a   (act_chunk),
    .b   (w_data),
    .cnt (pc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (w_valid && last_chunk) state_d = S_DECIDE;
      S_DECIDE: state_d = last_neuron ? S_DONE : S_FETCH;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counters, accumulator and registered result outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q    <= '0;
      neuron_q <= '0;
      chunk_q  <= '0;
      acc_q    <= '0;
      out_vec  <= '0;
      o_valid  <= 1'b0;
      o_bit    <= 1'b0;
      o_idx    <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            act_q    <= act_vec;
            neuron_q <= '0;
            chunk_q  <= '0;
            acc_q    <= '0;
            out_vec  <= '0;
          end
        end
        S_FETCH: begin
          if (w_valid) begin
            acc_q   <= acc_sum;
            chunk_q <= last_chunk ? '0 : chunk_q + 1'b1;
          end
        end
        S_DECIDE: begin
          o_valid           <= 1'b1;
          o_bit             <= dec_bit;
          o_idx             <= neuron_q;
          out_vec[neuron_q] <= dec_bit;
          acc_q             <= '0;
          if (!last_neuron) neuron_q <= neuron_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_layer_seq.sv
// Directed bench for bnn_layer_seq with default parameters (N=32, 4 neurons).
module tb_bnn_layer_seq;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] act_vec = '0;
  logic         w_req;
  logic [3:0]   w_addr;
  logic         w_valid = 1'b0;
  logic [7:0]   w_data = '0;
  logic         o_valid;
  logic [1:0]   o_idx;
  logic         o_bit;
  logic [3:0]   out_vec;
  logic         busy;
  logic         done;
`ifdef BNN_THRESH_EN
  logic [6:0]   thr = 7'd32;
`endif

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  bnn_layer_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .act_vec (act_vec),
`ifdef BNN_THRESH_EN
    .thr     (thr),
`endif
    .w_req   (w_req),
    .w_addr  (w_addr),
    .w_valid (w_valid),
    .w_data  (w_data),
    .o_valid (o_valid),
    .o_idx   (o_idx),
    .o_bit   (o_bit),
    .out_vec (out_vec),
    .busy    (busy),
    .done    (done)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // One run. Cycle n is the interval after the (n-1)th edge following the
  // edge that samples start. Weights are served from wm at 8 bits per address.
  task automatic run(input logic [31:0] act, input logic [127:0] wm,
                     input bit waitmode, input int busy_at,
                     output logic [3:0] bits, output int nval, output int dcyc,
                     output int ndone, output bit stable, output logic [3:0] ov_first);
    int cnt;
    int n;
    int tail;
    logic [3:0] last;
    bit prev_req;
    bit prev_val;
    bits = '0; nval = 0; dcyc = -1; ndone = 0; stable = 1'b1; ov_first = 'x;
    cnt = 0; last = '0; prev_req = 1'b0; prev_val = 1'b0;
    @(negedge clk);
    act_vec = act;
    start   = 1'b1;
    w_valid = !waitmode;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    tail = 0;
    while (n < 400 && tail < 3) begin
      @(negedge clk);
      if (busy_at == n) begin
        start   = 1'b1;
        act_vec = ~act;
      end else begin
        start = 1'b0;
      end
      if (n == 1) ov_first = out_vec;
      if (done) begin
        ndone++;
        if (dcyc < 0) dcyc = n;
      end
      if (o_valid) begin
        nval++;
        bits[o_idx] = o_bit;
      end
      if (dcyc >= 0) tail++;
      if (prev_req && !prev_val && (!w_req || w_addr != last)) stable = 1'b0;
      if (w_req) cnt = (prev_req && w_addr == last) ? cnt + 1 : 1;
      else cnt = 0;
      w_valid = waitmode ? (w_req && cnt >= 6) : 1'b1;
      w_data  = wm[w_addr*8 +: 8];
      prev_req = w_req;
      prev_val = w_valid;
      last     = w_addr;
      @(posedge clk);
      n++;
    end
    #1 start = 1'b0;
  endtask

  typedef struct {
    logic [31:0]  act;
    logic [127:0] wm;
    int           busy_at;
    logic [3:0]   exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [31:0] a;
    logic [3:0] bits;
    logic [3:0] ov1;
    int nval;
    int dcyc;
    int ndone;
    int seen;
    bit stable;

    a = 32'hA5A5_0F0F;
    tbl[0] = '{32'hFFFF_FFFF, {128{1'b1}}, 0, 4'b1111};
    tbl[1] = '{32'hFFFF_FFFF, 128'd0, 0, 4'b0000};
    tbl[2] = '{32'hFFFF_FFFF, {32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_7FFF, 32'h0000_FFFF}, 0, 4'b0101};
    tbl[3] = '{a, {a ^ 32'hFFFE_0000, a ^ 32'h0000_FFFF, ~a, a}, 0, 4'b1101};
    tbl[4] = '{32'h0000_0000, 128'd0, 7, 4'b1111};

    // Reset state while rst is held low.
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_w_req", w_req, 0);
    chk("rst_done", done, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_bit_idx", {o_bit, o_idx}, 0);
    chk("rst_out_vec", out_vec, 0);
    @(negedge clk);
    rst = 1'b1;

    // Zero-wait table runs.
    for (int i = 0; i < 5; i++) begin
      run(tbl[i].act, tbl[i].wm, 1'b0, tbl[i].busy_at, bits, nval, dcyc, ndone, stable, ov1);
      chk($sformatf("v%0d_out_vec", i), out_vec, tbl[i].exp);
      chk($sformatf("v%0d_o_bits", i), bits, tbl[i].exp);
      chk($sformatf("v%0d_n_o_valid", i), nval, 4);
      chk($sformatf("v%0d_done_cycle", i), dcyc, 21);
      chk($sformatf("v%0d_done_pulses", i), ndone, 1);
      chk($sformatf("v%0d_out_vec_cleared", i), ov1, 0);
    end

    // Five-cycle wait per chunk.
    run(tbl[3].act, tbl[3].wm, 1'b1, 0, bits, nval, dcyc, ndone, stable, ov1);
    chk("wait_out_vec", out_vec, tbl[3].exp);
    chk("wait_o_bits", bits, tbl[3].exp);
    chk("wait_done_cycle", dcyc, 101);
    chk("wait_req_addr_stable", stable, 1);
    chk("wait_n_o_valid", nval, 4);

`ifdef BNN_THRESH_EN
    thr = 7'd40;
    run(32'hFFFF_FFFF, {4{32'h0003_FFFF}}, 1'b0, 0, bits, nval, dcyc, ndone, stable, ov1);
    chk("thr40_out_vec", out_vec, 4'b0000);
    thr = 7'd36;
    run(32'hFFFF_FFFF, {4{32'h0003_FFFF}}, 1'b0, 0, bits, nval, dcyc, ndone, stable, ov1);
    chk("thr36_out_vec", out_vec, 4'b1111);
    thr = 7'd32;
`endif

    // Reset mid-run at cycle 10.
    @(negedge clk);
    act_vec = 32'hFFFF_FFFF;
    w_data  = 8'hFF;
    w_valid = 1'b1;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("pre_rst_out_vec", out_vec, 4'b0001);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_w_req", w_req, 0);
    chk("mid_rst_done_ovalid", {done, o_valid}, 0);
    chk("mid_rst_out_vec", out_vec, 0);
    chk("mid_rst_o_bit_idx", {o_bit, o_idx}, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_valid || done || busy) seen++;
    end
    chk("post_rst_idle_quiet", seen, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
